// File: rtl/result_frame_tx_pkg.sv
// Shared types and defaults for the result-frame transmitter.
package result_frame_tx_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_CNT, S_FETCH, S_CAPT, S_HI, S_LO, S_CSUM, S_FIN
    } state_t;

    typedef enum logic [1:0] {
        HS_IDLE, HS_START, HS_WAIT, HS_GAP
    } hs_state_t;

    localparam int          RFT_MAX_ELEMENTS = 100;
    localparam logic [7:0]  RFT_HEADER       = 8'hA5;

endpackage

// File: rtl/result_frame_tx_handshake.sv
// One byte at a time to the UART: hold tx_start until busy, wait for a tx_done
// rising edge, then enforce the inter-byte gap. ack pulses once per byte.
module uart_byte_handshake
    import result_frame_tx_pkg::*;
#(
    parameter int GAP_CYCLES = 12500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] data,
    output logic       ack,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic       tx_done
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    hs_state_t     hs;
    logic          done_q;
    logic [GW-1:0] gap_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs       <= HS_IDLE;
            done_q   <= 1'b0;
            gap_cnt  <= '0;
            ack      <= 1'b0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
        end else begin
            done_q <= tx_done;
            ack    <= 1'b0;
            case (hs)
                HS_IDLE: if (req) begin
                    tx_data  <= data;
                    tx_start <= 1'b1;
                    hs       <= HS_START;
                end
                HS_START: if (tx_busy) begin
                    tx_start <= 1'b0;
                    hs       <= HS_WAIT;
                end
                // ack is early so the sequencer can fetch the next word while the gap runs
                HS_WAIT: if (tx_done && !done_q) begin
                    ack     <= 1'b1;
                    gap_cnt <= '0;
                    hs      <= HS_GAP;
                end
                HS_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (req) begin
                            tx_data  <= data;
                            tx_start <= 1'b1;
                            hs       <= HS_START;
                        end else begin
                            hs <= HS_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: hs <= HS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/result_frame_tx.sv
// Frames the 16-bit result matrix as A5, count, hi/lo data bytes, 8-bit sum
// and streams it through the UART byte handshake.
module result_frame_tx
    import result_frame_tx_pkg::*;
#(
    parameter int         MAX_ELEMENTS = RFT_MAX_ELEMENTS,
    parameter int         ADDR_W       = 7,
    parameter int         GAP_CYCLES   = 12500,
    parameter logic [7:0] HEADER       = RFT_HEADER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [7:0] MAX_B = 8'(MAX_ELEMENTS);

    state_t      state;
    logic [7:0]  cnt;
    logic [7:0]  elem;
    logic [7:0]  elem_nxt;
    logic [7:0]  checksum;
    logic [15:0] word_q;
    logic        req;
    logic [7:0]  data;
    logic        ack;

    assign elem_nxt = elem + 8'd1;

    always_comb begin
        req  = 1'b1;
        data = 8'h00;
        case (state)
            S_HDR:   data = HEADER;
            S_CNT:   data = cnt;
            S_HI:    data = word_q[15:8];
            S_LO:    data = word_q[7:0];
            S_CSUM:  data = checksum;
            default: req  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 8'h00;
            elem     <= 8'h00;
            checksum <= 8'h00;
            word_q   <= 16'h0000;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done  <= 1'b0;
            rd_en <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    cnt      <= count;
                    checksum <= 8'h00;
                    elem     <= 8'h00;
                    err      <= (count > MAX_B);
                    if (count > MAX_B) begin
                        done <= 1'b1;
                    end else begin
                        busy  <= 1'b1;
                        state <= S_HDR;
                    end
                end
                S_HDR: if (ack) state <= S_CNT;
                S_CNT: if (ack) begin
                    checksum <= checksum + cnt;
                    if (cnt == 8'h00) begin
                        state <= S_CSUM;
                    end else begin
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_CAPT;
                S_CAPT: begin
                    word_q <= rd_data;
                    state  <= S_HI;
                end
                S_HI: if (ack) begin
                    checksum <= checksum + word_q[15:8];
                    state    <= S_LO;
                end
                S_LO: if (ack) begin
                    checksum <= checksum + word_q[7:0];
                    elem     <= elem_nxt;
                    if (elem_nxt == cnt) begin
                        state <= S_CSUM;
                    end else begin
                        rd_en   <= 1'b1;
                        rd_addr <= elem_nxt[ADDR_W-1:0];
                        state   <= S_FETCH;
                    end
                end
                S_CSUM: if (ack) state <= S_FIN;
                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    uart_byte_handshake #(.GAP_CYCLES(GAP_CYCLES)) u_hs (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data     (data),
        .ack      (ack),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

endmodule

// File: doc/result_frame_tx.md
Name: result_frame_tx

Overview:
- Downstream stage of the pipelined matrix-multiply core. It streams the 16-bit result matrix out of the result store over the 8-bit UART transmitter, sending both bytes of every element instead of only the low byte.
- It wraps the results in a framed packet: header, element count, data bytes high-first, then an additive checksum.
- It drives the transmitter through a start/busy/done handshake and enforces an inter-byte gap.

Parameters:
- MAX_ELEMENTS, 100: maximum result count (10x10).
- ADDR_W, 7: result-store address width; must satisfy 2^ADDR_W >= MAX_ELEMENTS.
- GAP_CYCLES, 12500: idle clk cycles inserted after each byte's tx_done edge, before the next tx_start.
- HEADER, 8'hA5: frame start byte.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a frame; ignored while busy=1
- count  in  8  number of results to send; latched on start
- rd_en  out  1  result-store read strobe
- rd_addr  out  ADDR_W  result-store read address
- rd_data  in  16  result word, valid exactly 1 cycle after rd_en
- tx_data  out  8  byte to the transmitter
- tx_start  out  1  transmit request
- tx_busy  in  1  transmitter busy (slow txClk domain, treated as level)
- tx_done  in  1  transmitter done (level, may stay high for many clk cycles)
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse at frame end
- err  out  1  sticky; set when count > MAX_ELEMENTS; cleared by the next accepted start

Behaviour:
- Reset (async, asserted): state=IDLE; all outputs 0; tx_data=0; rd_addr=0; checksum=0; gap counter=0; internal done-edge register=0.
- Byte handshake (SEND sub-sequence):
  - Drive tx_data and set tx_start=1; hold both until tx_busy=1 is sampled, then clear tx_start.
  - Wait for a rising edge of tx_done, detected against a registered copy of tx_done.
  - Then enter GAP for exactly GAP_CYCLES cycles.
  - A tx_done that is already high when SEND begins is not an edge.
  - If tx_busy is high when SEND is entered, tx_start is still raised, and the edge wait starts after that busy is seen.
- States:
  - IDLE: busy=0. On start:
    - Latch count into cnt; checksum=0; elem=0; busy=1.
    - If count > MAX_ELEMENTS: set err=1, pulse done, stay IDLE.
    - Otherwise go to HDR.
  - HDR: send HEADER; the header is not included in the checksum; then go to CNT.
  - CNT: send cnt; checksum += cnt. If cnt==0 go to CSUM, else go to FETCH.
  - FETCH: rd_en=1 for one cycle with rd_addr=elem; go to CAPT.
  - CAPT: register rd_data into word_q; go to HI.
  - HI: send word_q[15:8]; checksum += byte; go to LO.
  - LO: send word_q[7:0]; checksum += byte; elem += 1. If elem == cnt after the increment, go to CSUM; else go to FETCH.
  - CSUM: send checksum[7:0]; go to FIN.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- Arithmetic: the checksum is an 8-bit sum that wraps mod 256.
- Frame length: 3 + 2*cnt bytes.
- Read latency: exactly one read per element; rd_addr is stable during CAPT.
- Reset mid-frame: abort immediately; tx_start drops to 0; no done pulse; the transmitter may finish its current byte on its own.
- Simultaneous start and FIN: start is ignored; busy is still high in that cycle.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, HDR, CNT, FETCH, CAPT, HI, LO, CSUM, FIN);
  - the HEADER default;
  - MAX_ELEMENTS.
- One natural sub-module: uart_byte_handshake.
  - Implements tx_start hold, busy acknowledge, done-edge detect and the GAP counter.
  - Interface: req/byte in, ack pulse out.
  - The FSM only sequences bytes.

Test Plan:
- count=4, store=[0x0102,0x0304,0x0506,0x0708] -> bytes A5 04 01 02 03 04 05 06 07 08 28; one done pulse; exactly 4 rd_en pulses, at addresses 0..3.
- count=0 -> bytes A5 00 00; no rd_en; done pulse.
- count=101 -> err=1, done pulse, no tx_start; a following start with count=1 and store[0]=0xFFFF gives A5 01 FF FF FF (0x1FF mod 256) and err=0.
- GAP_CYCLES=10, transmitter model holds tx_done high 50 cycles -> exactly one byte counted per edge; next tx_start rises exactly 10 cycles after each tx_done rising edge.
- Assert rst during the LO byte of element 2 -> tx_start, busy, rd_en are 0 in the same cycle; no done; a restart frame is correct.
- Second start pulse mid-frame -> ignored; frame bytes are unchanged.
